mem_stage: RTL and testbench

//  MEM stage of the 5-stage RISC-V core; sits between the ex/mem pipeline register and mem/wb.

---
 rtl/mem_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RISC-V core: runs byte/half/word loads and stores as a
// sequence of single-byte beats on a request/ack bus and stalls the pipeline until the access finishes.
module mem_stage #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        in_op,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_sdata,
    input  logic              in_we,
    input  logic [4:0]        in_waddr,
    input  logic [31:0]       in_wdata,
    output logic              stall_req,
    output logic              mem_we,
    output logic [4:0]        mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              bus_req,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic              bus_ack,
    input  logic [7:0]        bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t            r_state;
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_sdata;
    logic              r_we;
    logic [4:0]        r_waddr;
    logic [1:0]        r_beat;
    logic [31:0]       r_buf;

    logic              w_is_mem;
    logic              w_is_store;
    logic [1:0]        w_last_beat;
    logic [31:0]       w_load_data;
    logic              w_unused_addr;

    // Only the low ADDR_W address bits reach the bus; the rest wrap away.
    assign w_unused_addr = ^in_addr[31:ADDR_W];

    assign w_is_mem   = (in_op >= OP_LB) && (in_op <= OP_SW);
    assign w_is_store = (r_op == OP_SB) || (r_op == OP_SH) || (r_op == OP_SW);

    always_comb begin
        w_last_beat = 2'd0;
        case (r_op)
            OP_LH, OP_LHU, OP_SH: w_last_beat = 2'd1;
            OP_LW, OP_SW:         w_last_beat = 2'd3;
            default:              w_last_beat = 2'd0;
        endcase
    end

    always_comb begin
        w_load_data = r_buf;
        case (r_op)
            OP_LB:   w_load_data = {{24{r_buf[7]}}, r_buf[7:0]};
            OP_LH:   w_load_data = {{16{r_buf[15]}}, r_buf[15:0]};
            OP_LBU:  w_load_data = {24'h0, r_buf[7:0]};
            OP_LHU:  w_load_data = {16'h0, r_buf[15:0]};
            default: w_load_data = r_buf;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_op    <= 4'd0;
            r_addr  <= '0;
            r_sdata <= 32'd0;
            r_we    <= 1'b0;
            r_waddr <= 5'd0;
            r_beat  <= 2'd0;
            r_buf   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem) begin
                        r_op    <= in_op;
                        r_addr  <= in_addr[ADDR_W-1:0];
                        r_sdata <= in_sdata;
                        r_we    <= in_we;
                        r_waddr <= in_waddr;
                        r_beat  <= 2'd0;
                        r_buf   <= 32'd0;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (bus_ack) begin
                        if (!w_is_store) begin
                            r_buf[{r_beat, 3'b000} +: 8] <= bus_rdata;
                        end
                        if (r_beat == w_last_beat) begin
                            r_state <= S_DONE;
                        end else begin
                            r_beat <= r_beat + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_beat  <= 2'd0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so the bus request drops in the same cycle reset asserts.
    always_comb begin
        stall_req = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = 5'd0;
        mem_wdata = 32'd0;
        bus_req   = 1'b0;
        bus_rw    = 1'b0;
        bus_addr  = '0;
        bus_wdata = 8'd0;
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem) begin
                        stall_req = 1'b1;
                    end else begin
                        mem_we    = in_we & (|in_waddr);
                        mem_waddr = in_waddr;
                        mem_wdata = in_wdata;
                    end
                end
                S_ACCESS: begin
                    stall_req = 1'b1;
                    bus_req   = 1'b1;
                    bus_rw    = w_is_store;
                    bus_addr  = r_addr + ADDR_W'(r_beat);
                    bus_wdata = r_sdata[{r_beat, 3'b000} +: 8];
                end
                S_DONE: begin
                    if (!w_is_store) begin
                        mem_we    = r_we & (|r_waddr);
                        mem_waddr = r_waddr;
                        mem_wdata = w_load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed and random loads/stores against a byte-array memory model,
// with a bus responder that inserts wait states and scrambles upstream inputs while the stage stalls.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_sdata;
    logic        in_we;
    logic [4:0]  in_waddr;
    logic [31:0] in_wdata;
    logic        stall_req;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        bus_req;
    logic        bus_rw;
    logic [16:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] memModel [0:131071];

    mem_stage #(.ADDR_W(17)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_sdata  (in_sdata),
        .in_we     (in_we),
        .in_waddr  (in_waddr),
        .in_wdata  (in_wdata),
        .stall_req (stall_req),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .bus_req   (bus_req),
        .bus_rw    (bus_rw),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scrambleInputs();
        in_op    = 4'($urandom);
        in_addr  = $urandom;
        in_sdata = $urandom;
        in_we    = 1'($urandom);
        in_waddr = 5'($urandom);
        in_wdata = $urandom;
    endtask

    // One instruction through the stage; waitFix<0 picks 0..2 wait cycles per beat at random.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                                 input int waitFix, input string name,
                                 output logic [31:0] obsData, output int obsStall);
        bit          isLoad;
        bit          isStore;
        int          n;
        int          waits;
        int          expStall;
        logic [16:0] a;
        logic [7:0]  b [4];
        logic [31:0] expData;

        isLoad  = (op >= 4'd1) && (op <= 4'd5);
        isStore = (op >= 4'd6) && (op <= 4'd8);
        n = (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 :
            (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
        for (int i = 0; i < 4; i++) b[i] = 8'h00;
        obsStall = 0;

        @(negedge clk);
        in_op = op; in_addr = addr; in_sdata = sdata;
        in_we = we; in_waddr = waddr; in_wdata = wdata;
        bus_ack = 1'b0; bus_rdata = 8'($urandom);
        #1;
        if (!(isLoad || isStore)) begin
            checkOutput({name, " pt stall"}, 32'(stall_req), 32'd0);
            checkOutput({name, " pt we"}, 32'(mem_we), 32'(we && (waddr != 5'd0)));
            checkOutput({name, " pt waddr"}, 32'(mem_waddr), 32'(waddr));
            checkOutput({name, " pt wdata"}, mem_wdata, wdata);
            checkOutput({name, " pt req"}, 32'(bus_req), 32'd0);
            obsData = mem_wdata;
            return;
        end
        checkOutput({name, " accept stall"}, 32'(stall_req), 32'd1);
        checkOutput({name, " accept we"}, 32'(mem_we), 32'd0);
        checkOutput({name, " accept req"}, 32'(bus_req), 32'd0);
        obsStall += stall_req ? 1 : 0;
        expStall = 1;

        for (int k = 0; k < n; k++) begin
            a = addr[16:0] + 17'(k);
            waits = (waitFix < 0) ? int'($urandom_range(0, 2)) : waitFix;
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                scrambleInputs();
                bus_ack   = (w == waits);
                bus_rdata = (w == waits) ? memModel[a] : 8'($urandom);
                #1;
                checkOutput({name, " beat req"}, 32'(bus_req), 32'd1);
                checkOutput({name, " beat addr"}, 32'(bus_addr), 32'(a));
                checkOutput({name, " beat rw"}, 32'(bus_rw), 32'(isStore));
                checkOutput({name, " beat stall"}, 32'(stall_req), 32'd1);
                checkOutput({name, " beat we"}, 32'(mem_we), 32'd0);
                if (isStore) checkOutput({name, " beat wdata"}, 32'(bus_wdata), 32'(sdata[k*8 +: 8]));
                obsStall += stall_req ? 1 : 0;
                expStall++;
            end
            if (isStore) memModel[a] = sdata[k*8 +: 8];
            b[k] = memModel[a];
        end

        case (op)
            4'd1:    expData = {{24{b[0][7]}}, b[0]};
            4'd2:    expData = {{16{b[1][7]}}, b[1], b[0]};
            4'd3:    expData = {b[3], b[2], b[1], b[0]};
            4'd4:    expData = {24'h0, b[0]};
            4'd5:    expData = {16'h0, b[1], b[0]};
            default: expData = 32'h0;
        endcase

        @(negedge clk);
        scrambleInputs();
        bus_ack = 1'b0;
        #1;
        checkOutput({name, " done req"}, 32'(bus_req), 32'd0);
        checkOutput({name, " done stall"}, 32'(stall_req), 32'd0);
        checkOutput({name, " done we"}, 32'(mem_we), 32'(isLoad && we && (waddr != 5'd0)));
        checkOutput({name, " done waddr"}, 32'(mem_waddr), isLoad ? 32'(waddr) : 32'd0);
        checkOutput({name, " done wdata"}, mem_wdata, expData);
        checkOutput({name, " stall cycles"}, 32'(obsStall), 32'(expStall));
        obsData = mem_wdata;
    endtask

    initial begin
        logic [31:0] d;
        int          s;
        logic [3:0]  rop;
        logic [16:0] a;

        for (int i = 0; i < 131072; i++) memModel[i] = 8'($urandom);
        rst = 1'b0;
        bus_ack = 1'b0; bus_rdata = 8'h00;
        in_op = 4'd0; in_addr = 32'h0; in_sdata = 32'h0;
        in_we = 1'b1; in_waddr = 5'd5; in_wdata = 32'h1234;
        #1;
        checkOutput("reset we", 32'(mem_we), 32'd0);
        checkOutput("reset waddr", 32'(mem_waddr), 32'd0);
        checkOutput("reset wdata", mem_wdata, 32'd0);
        checkOutput("reset stall", 32'(stall_req), 32'd0);
        checkOutput("reset req", 32'(bus_req), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        applyStimulus(4'd0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234, 0, "add", d, s);
        checkOutput("add const", d, 32'h0000_1234);

        memModel[17'h100] = 8'h11; memModel[17'h101] = 8'h22;
        memModel[17'h102] = 8'h33; memModel[17'h103] = 8'h44;
        applyStimulus(4'd3, 32'h100, 32'h0, 1'b1, 5'd7, 32'h0, 0, "lw", d, s);
        checkOutput("lw const", d, 32'h4433_2211);
        checkOutput("lw stall5", 32'(s), 32'd5);

        memModel[17'h7] = 8'h80;
        applyStimulus(4'd1, 32'h7, 32'h0, 1'b1, 5'd3, 32'h0, 0, "lb", d, s);
        checkOutput("lb const", d, 32'hFFFF_FF80);
        applyStimulus(4'd4, 32'h7, 32'h0, 1'b1, 5'd3, 32'h0, 0, "lbu", d, s);
        checkOutput("lbu const", d, 32'h0000_0080);
        memModel[17'h40] = 8'h34; memModel[17'h41] = 8'hF2;
        applyStimulus(4'd2, 32'h40, 32'h0, 1'b1, 5'd9, 32'h0, 0, "lh", d, s);
        checkOutput("lh const", d, 32'hFFFF_F234);

        applyStimulus(4'd7, 32'h0001_FFFF, 32'hAABB_CCDD, 1'b1, 5'd4, 32'h0, 0, "sh wrap", d, s);
        applyStimulus(4'd5, 32'h0001_FFFF, 32'h0, 1'b1, 5'd4, 32'h0, 0, "lhu wrap", d, s);
        checkOutput("sh readback", d, 32'h0000_CCDD);

        applyStimulus(4'd3, 32'h200, 32'h0, 1'b1, 5'd12, 32'h0, 3, "lw slow", d, s);
        checkOutput("lw slow stall17", 32'(s), 32'd17);

        applyStimulus(4'd3, 32'h300, 32'h0, 1'b1, 5'd0, 32'h0, 0, "lw x0", d, s);
        applyStimulus(4'd12, 32'h10, 32'h0, 1'b1, 5'd6, 32'hCAFE, 0, "op12", d, s);

        // Reset arrives while the third beat of a word load is on the bus.
        @(negedge clk);
        in_op = 4'd3; in_addr = 32'h500; in_we = 1'b1; in_waddr = 5'd8;
        bus_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            scrambleInputs();
            a = 17'h500 + 17'(k);
            bus_ack = 1'b1; bus_rdata = memModel[a];
        end
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checkOutput("abort beat2 addr", 32'(bus_addr), 32'h502);
        rst = 1'b0;
        #1;
        checkOutput("abort req", 32'(bus_req), 32'd0);
        checkOutput("abort stall", 32'(stall_req), 32'd0);
        checkOutput("abort we", 32'(mem_we), 32'd0);
        @(negedge clk);
        in_op = 4'd0;
        rst = 1'b1;
        applyStimulus(4'd1, 32'h520, 32'h0, 1'b1, 5'd2, 32'h0, 0, "lb post", d, s);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 10));
            applyStimulus(rop, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, -1, "rand", d, s);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
